// File: rtl/stage_sequencer_pkg.sv
// stage_sequencer_pkg: state encoding shared by the stage sequencer files.
package stage_sequencer_pkg;
   typedef enum logic [1:0] {
      SEQ_RUN  = 2'd0,
      SEQ_HOLD = 2'd1,
      SEQ_IDLE = 2'd2
   } seq_state_e;
endpackage

// File: rtl/stage_sequencer_tick_decode.sv
// stage_sequencer_tick_decode: per-stage clip of slot/pulse length and tick/last-cycle terms.
module stage_sequencer_tick_decode #(
   parameter int LEN_W = 4
) (
   input  logic [LEN_W-1:0] i_slot_len,
   input  logic [LEN_W-1:0] i_pulse_len,
   input  logic [LEN_W-1:0] i_cnt,
   input  logic             i_sel,
   input  logic             i_run,
   output logic             o_tick,
   output logic             o_last
);
   logic [LEN_W-1:0] w_eff_slot, w_eff_pulse;
   // a zero slot still occupies one cycle; the pulse can never outlast its slot
   assign w_eff_slot  = (i_slot_len == '0) ? LEN_W'(1) : i_slot_len;
   assign w_eff_pulse = (i_pulse_len > w_eff_slot) ? w_eff_slot : i_pulse_len;
   assign o_tick      = i_run && i_sel && (i_cnt < w_eff_pulse);
   assign o_last      = i_sel && (i_cnt == w_eff_slot - LEN_W'(1));
endmodule

// File: rtl/stage_sequencer.sv
// stage_sequencer: frame/slot tick generator with stall hold, flush restart and frame single-step.
module stage_sequencer
   import stage_sequencer_pkg::*;
#(
   parameter int NUM_STAGES = 5,
   parameter int LEN_W      = 4,
   parameter int DEF_SLOT   = 5,
   parameter int DEF_PULSE  = 1,
   localparam int IDX_W     = $clog2(NUM_STAGES)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic                          flush,
   input  logic                          step_mode,
   input  logic                          step,
   input  logic [NUM_STAGES*LEN_W-1:0]   cfg_slot_len,
   input  logic [NUM_STAGES*LEN_W-1:0]   cfg_pulse_len,
   output logic [NUM_STAGES-1:0]         tick,
   output logic [IDX_W-1:0]              stage_idx,
   output logic [LEN_W-1:0]              slot_cnt,
   output logic                          frame_done,
   output logic                          idle
);
   seq_state_e                  r_st, w_st;
   logic [IDX_W-1:0]            r_idx, w_idx;
   logic [LEN_W-1:0]            r_cnt, w_cnt;
   logic                        r_fresh, w_fresh, w_load, w_run;
   logic                        r_last, r_done, r_idle;
   logic [NUM_STAGES*LEN_W-1:0] r_slot, r_pulse, w_slot, w_pulse;
   logic [NUM_STAGES-1:0]       r_tick, w_tick, w_last_k;

   // r_fresh marks a frame that is positioned at stage 0 but has not started (after reset or flush)
   always_comb begin
      w_st    = r_st;
      w_idx   = r_idx;
      w_cnt   = r_cnt;
      w_fresh = r_fresh;
      w_load  = 1'b0;
      if (flush) begin
         w_st    = stall ? SEQ_HOLD : SEQ_RUN;
         w_idx   = '0;
         w_cnt   = '0;
         w_fresh = 1'b1;
      end else if (r_st == SEQ_IDLE) begin
         w_st   = (step || !step_mode) ? SEQ_RUN : SEQ_IDLE;
         w_load = step || !step_mode;
      end else if (r_fresh) begin
         w_st    = stall ? SEQ_HOLD : SEQ_RUN;
         w_fresh = stall;
         w_load  = !stall;
      end else if (r_st == SEQ_HOLD) begin
         w_st = stall ? SEQ_HOLD : SEQ_RUN;
      end else if (r_done) begin
         w_idx   = '0;
         w_cnt   = '0;
         w_st    = step_mode ? SEQ_IDLE : (stall ? SEQ_HOLD : SEQ_RUN);
         w_fresh = !step_mode && stall;
         w_load  = !step_mode && !stall;
      end else begin
         w_st  = stall ? SEQ_HOLD : SEQ_RUN;
         w_cnt = r_last ? '0 : r_cnt + LEN_W'(1);
         w_idx = r_last ? r_idx + IDX_W'(1) : r_idx;
      end
   end

   assign w_slot  = w_load ? cfg_slot_len  : r_slot;
   assign w_pulse = w_load ? cfg_pulse_len : r_pulse;
   assign w_run   = (w_st == SEQ_RUN) && !w_fresh;

   for (genvar g = 0; g < NUM_STAGES; g++) begin : g_dec
      stage_sequencer_tick_decode #(.LEN_W(LEN_W)) u_dec (
         .i_slot_len  (w_slot[g*LEN_W +: LEN_W]),
         .i_pulse_len (w_pulse[g*LEN_W +: LEN_W]),
         .i_cnt       (w_cnt),
         .i_sel       (w_idx == IDX_W'(g)),
         .i_run       (w_run),
         .o_tick      (w_tick[g]),
         .o_last      (w_last_k[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_st    <= SEQ_RUN;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_fresh <= 1'b1;
         r_slot  <= {NUM_STAGES{LEN_W'(DEF_SLOT)}};
         r_pulse <= {NUM_STAGES{LEN_W'(DEF_PULSE)}};
         r_tick  <= '0;
         r_last  <= 1'b0;
         r_done  <= 1'b0;
         r_idle  <= 1'b0;
      end else begin
         r_st    <= w_st;
         r_idx   <= w_idx;
         r_cnt   <= w_cnt;
         r_fresh <= w_fresh;
         r_slot  <= w_slot;
         r_pulse <= w_pulse;
         r_tick  <= w_tick;
         r_last  <= |w_last_k;
         r_done  <= w_run && (w_idx == IDX_W'(NUM_STAGES-1)) && (|w_last_k);
         r_idle  <= (w_st == SEQ_IDLE);
      end
   end

   assign tick       = r_tick;
   assign stage_idx  = r_idx;
   assign slot_cnt   = r_cnt;
   assign frame_done = r_done;
   assign idle       = r_idle;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed and random scenarios checked against a frame-position reference model.
module tb_stage_sequencer;
   localparam int N = 5;
   localparam int LW = 4;
   localparam int IW = 3;
   localparam int OW = N + IW + LW + 2;
   localparam int M_RUN = 0, M_HOLD = 1, M_IDLE = 2;

   logic clk = 1'b0;
   logic rst, stall, flush, step_mode, step;
   logic [N*LW-1:0] cfg_slot_len, cfg_pulse_len;
   logic [N-1:0] tick;
   logic [IW-1:0] stage_idx;
   logic [LW-1:0] slot_cnt;
   logic frame_done, idle;
   int checks = 0, errors = 0;

   int m_mode, m_p;
   bit m_pend;
   int m_slot[N], m_pulse[N];

   stage_sequencer #(.NUM_STAGES(N), .LEN_W(LW), .DEF_SLOT(5), .DEF_PULSE(1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .step_mode(step_mode), .step(step),
      .cfg_slot_len(cfg_slot_len), .cfg_pulse_len(cfg_pulse_len), .tick(tick),
      .stage_idx(stage_idx), .slot_cnt(slot_cnt), .frame_done(frame_done), .idle(idle)
   );

   always #5 clk = ~clk;

   function automatic int eff_s(int k);
      return (m_slot[k] == 0) ? 1 : m_slot[k];
   endfunction

   function automatic int frame_len();
      int s = 0;
      for (int k = 0; k < N; k++) s += eff_s(k);
      return s;
   endfunction

   task automatic model_load();
      for (int k = 0; k < N; k++) begin
         m_slot[k]  = int'(cfg_slot_len[k*LW +: LW]);
         m_pulse[k] = int'(cfg_pulse_len[k*LW +: LW]);
      end
   endtask

   task automatic model_reset();
      m_mode = M_RUN;
      m_pend = 1'b1;
      m_p    = 0;
      for (int k = 0; k < N; k++) begin
         m_slot[k]  = 5;
         m_pulse[k] = 1;
      end
   endtask

   task automatic model_edge();
      if (flush) begin
         m_mode = stall ? M_HOLD : M_RUN;
         m_pend = 1'b1;
         m_p    = 0;
      end else if (m_mode == M_IDLE) begin
         if (step || !step_mode) begin
            m_mode = M_RUN;
            m_p    = 0;
            model_load();
         end
      end else if (m_pend) begin
         if (stall) m_mode = M_HOLD;
         else begin
            m_mode = M_RUN;
            m_pend = 1'b0;
            model_load();
         end
      end else if (m_mode == M_HOLD) begin
         if (!stall) m_mode = M_RUN;
      end else if (m_p == frame_len() - 1) begin
         m_p = 0;
         if (step_mode) m_mode = M_IDLE;
         else if (stall) begin
            m_mode = M_HOLD;
            m_pend = 1'b1;
         end else model_load();
      end else begin
         m_p++;
         if (stall) m_mode = M_HOLD;
      end
   endtask

   // expected outputs derived from the position within the frame by prefix sums of slot lengths
   function automatic logic [OW-1:0] exp_out();
      logic [N-1:0] t = '0;
      int si = 0, sc = 0, acc = 0, ep;
      bit fd = 1'b0;
      if (m_mode != M_IDLE && !m_pend) begin
         for (int k = 0; k < N; k++) begin
            if (m_p >= acc && m_p < acc + eff_s(k)) begin
               si = k;
               sc = m_p - acc;
            end
            acc += eff_s(k);
         end
         if (m_mode == M_RUN) begin
            ep = (m_pulse[si] < eff_s(si)) ? m_pulse[si] : eff_s(si);
            if (sc < ep) t[si] = 1'b1;
            fd = (m_p == acc - 1);
         end
      end
      return {t, IW'(si), LW'(sc), fd, m_mode == M_IDLE};
   endfunction

   function automatic logic [OW-1:0] obs();
      return {tick, stage_idx, slot_cnt, frame_done, idle};
   endfunction

   task automatic edge_step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; stall = 0; flush = 0; step_mode = 0; step = 0;
      cfg_slot_len = 20'h55555; cfg_pulse_len = 20'h11111;
      model_reset();
      #2;
      if (obs() !== '0) begin errors++; $display("FAIL reset outputs got %h exp 0", obs()); end
      checks++;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_defaults();
      int fd = -1, t1 = -1, t0 = -1;
      for (int i = 0; i < 30; i++) begin
         edge_step();
         if (obs() !== exp_out()) begin errors++; $display("FAIL defaults cyc %0d got %h exp %h", i, obs(), exp_out()); end
         checks++;
         if (frame_done && fd < 0) fd = i;
         if (tick[1] && t1 < 0) t1 = i;
         if (tick[0] && i > 0 && t0 < 0) t0 = i;
      end
      if (fd !== 24 || t1 !== 5 || t0 !== 25) begin errors++; $display("FAIL defaults timing got fd=%0d t1=%0d t0=%0d exp 24 5 25", fd, t1, t0); end
      checks++;
   endtask

   task automatic test_irregular();
      int f0 = -1, f1 = -1;
      int cnt[N] = '{default: 0};
      cfg_slot_len = 20'h27013; cfg_pulse_len = 20'h09412;
      flush = 1'b1;
      edge_step();
      flush = 1'b0;
      for (int i = 0; i < 40; i++) begin
         edge_step();
         if (obs() !== exp_out()) begin errors++; $display("FAIL irregular cyc %0d got %h exp %h", i, obs(), exp_out()); end
         checks++;
         if (f0 >= 0 && f1 < 0)
            for (int k = 0; k < N; k++) cnt[k] += int'(tick[k]);
         if (frame_done) begin
            if (f0 < 0) f0 = i; else if (f1 < 0) f1 = i;
         end
      end
      if (f0 !== 13 || f1 - f0 !== 14) begin errors++; $display("FAIL irregular frame got fd0=%0d len=%0d exp 13 14", f0, f1 - f0); end
      checks++;
      if (cnt[0] !== 2 || cnt[1] !== 1 || cnt[2] !== 1 || cnt[3] !== 7 || cnt[4] !== 0) begin
         errors++;
         $display("FAIL irregular widths got %0d %0d %0d %0d %0d exp 2 1 1 7 0", cnt[0], cnt[1], cnt[2], cnt[3], cnt[4]);
      end
      checks++;
   endtask

   task automatic test_stall();
      int fd = -1, t2 = 0, sc = 0;
      bit started = 1'b0;
      cfg_slot_len = 20'h55555; cfg_pulse_len = 20'h33333;
      flush = 1'b1;
      edge_step();
      flush = 1'b0;
      for (int c = 0; c < 32; c++) begin
         edge_step();
         if (obs() !== exp_out()) begin errors++; $display("FAIL stall cyc %0d got %h exp %h", c, obs(), exp_out()); end
         checks++;
         if (frame_done && fd < 0) fd = c;
         t2 += int'(tick[2]);
         if (!started && stage_idx == 3'd2 && slot_cnt == 4'd0) begin started = 1'b1; sc = 3; end
         stall = (sc > 0);
         if (sc > 0) sc--;
      end
      if (fd !== 27 || t2 !== 3) begin errors++; $display("FAIL stall frame got fd=%0d t2=%0d exp 27 3", fd, t2); end
      checks++;
   endtask

   task automatic test_step();
      int n = 0;
      step_mode = 1'b1;
      while (!idle && n < 60) begin
         edge_step();
         if (obs() !== exp_out()) begin errors++; $display("FAIL step_run cyc %0d got %h exp %h", n, obs(), exp_out()); end
         checks++;
         n++;
      end
      if (!idle) begin errors++; $display("FAIL step_wait got idle=0 exp 1 within 60 cycles"); end
      checks++;
      for (int i = 0; i < 10; i++) begin
         stall = (i == 4);
         edge_step();
         if (obs() !== exp_out() || tick !== '0) begin errors++; $display("FAIL step_idle cyc %0d got %h exp %h", i, obs(), exp_out()); end
         checks++;
      end
      stall = 1'b0;
      step = 1'b1;
      edge_step();
      step = 1'b0;
      if (tick !== 5'b00001 || idle !== 1'b0 || obs() !== exp_out()) begin
         errors++; $display("FAIL step_go got tick=%b idle=%b exp tick=00001 idle=0", tick, idle);
      end
      checks++;
      step_mode = 1'b0;
   endtask

   task automatic test_flush_stall();
      int n = 0;
      while (stage_idx != 3'd3 && n < 60) begin
         edge_step();
         n++;
      end
      if (stage_idx !== 3'd3) begin errors++; $display("FAIL fs_wait got stage=%0d exp 3", stage_idx); end
      checks++;
      flush = 1'b1; stall = 1'b1;
      edge_step();
      flush = 1'b0;
      if (stage_idx !== '0 || tick !== '0 || obs() !== exp_out()) begin
         errors++; $display("FAIL fs_entry got %h exp %h", obs(), exp_out());
      end
      checks++;
      for (int i = 0; i < 8; i++) begin
         stall = (i < 3);
         edge_step();
         if (obs() !== exp_out()) begin errors++; $display("FAIL fs_hold cyc %0d got %h exp %h", i, obs(), exp_out()); end
         checks++;
      end
   endtask

   task automatic test_cfg_mid();
      int n = 0;
      cfg_slot_len = 20'h55555; cfg_pulse_len = 20'h22222;
      flush = 1'b1;
      edge_step();
      flush = 1'b0;
      for (int i = 0; i < 8; i++) edge_step();
      cfg_slot_len = 20'h31423; cfg_pulse_len = 20'h43214;
      for (int i = 0; i < 40; i++) begin
         edge_step();
         if (obs() !== exp_out()) begin errors++; $display("FAIL cfg_mid cyc %0d got %h exp %h", i, obs(), exp_out()); end
         checks++;
      end
      while (tick == '0 && n < 40) begin
         edge_step();
         n++;
      end
      #2 rst = 1'b0;
      #1;
      if (obs() !== '0) begin errors++; $display("FAIL async_rst got %h exp 0", obs()); end
      checks++;
      model_reset();
      #1 rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         edge_step();
         if (obs() !== exp_out()) begin errors++; $display("FAIL post_rst cyc %0d got %h exp %h", i, obs(), exp_out()); end
         checks++;
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         stall = ($urandom_range(0, 9) < 2);
         flush = ($urandom_range(0, 49) == 0);
         step  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 59) == 0) step_mode = ~step_mode;
         if ($urandom_range(0, 19) == 0) cfg_slot_len = 20'($urandom);
         if ($urandom_range(0, 19) == 0) cfg_pulse_len = 20'($urandom);
         edge_step();
         if (obs() !== exp_out()) begin errors++; $display("FAIL random cyc %0d got %h exp %h", i, obs(), exp_out()); end
         checks++;
      end
   endtask

   initial begin
      test_reset();
      test_defaults();
      test_irregular();
      test_stall();
      test_step();
      test_flush_stall();
      test_cfg_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
